easyaxi_rd_slice: RTL

EASYAXI_RD_SLICE -- requirements
Module: easyaxi_rd_slice

---
 rtl/easyaxi_rd_slice.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/easyaxi_rd_slice.sv
// AXI read-path register slice: 2-entry skid buffers on the R channel and, when
// EASYAXI_RD_SLICE_AR_EN is defined, on the AR channel (otherwise AR passes straight through).

`ifndef AXI_ID_W
`define AXI_ID_W 4
`endif
`ifndef AXI_ADDR_W
`define AXI_ADDR_W 32
`endif
`ifndef AXI_LEN_W
`define AXI_LEN_W 8
`endif
`ifndef AXI_SIZE_W
`define AXI_SIZE_W 3
`endif
`ifndef AXI_BURST_W
`define AXI_BURST_W 2
`endif
`ifndef AXI_DATA_W
`define AXI_DATA_W 32
`endif
`ifndef AXI_RESP_W
`define AXI_RESP_W 2
`endif

// Two-entry in-order skid buffer; both handshake outputs come straight from flops.
module easyaxi_rd_slice_skid #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic [1:0]   count_reg, count_next;
  logic [W-1:0] head_reg, head_next;
  logic [W-1:0] tail_reg, tail_next;
  logic         in_ready_reg;
  logic         out_valid_reg;
  logic         push;
  logic         pop;

  assign push = in_valid & in_ready_reg;
  assign pop  = out_valid_reg & out_ready;

  // head_reg is always the oldest entry, tail_reg the second one when full
  always_comb begin
    count_next = count_reg;
    head_next  = head_reg;
    tail_next  = tail_reg;
    case ({push, pop})
      2'b10: begin
        count_next = count_reg + 2'd1;
        if (count_reg == 2'd0) begin
          head_next = in_data;
        end else begin
          tail_next = in_data;
        end
      end
      2'b01: begin
        count_next = count_reg - 2'd1;
        head_next  = tail_reg;
      end
      2'b11: begin
        if (count_reg == 2'd1) begin
          head_next = in_data;
        end else begin
          head_next = tail_reg;
          tail_next = in_data;
        end
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg     <= 2'd0;
      head_reg      <= '0;
      tail_reg      <= '0;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
    end else begin
      count_reg     <= count_next;
      head_reg      <= head_next;
      tail_reg      <= tail_next;
      in_ready_reg  <= (count_next != 2'd2);
      out_valid_reg <= (count_next != 2'd0);
    end
  end

  assign in_ready  = in_ready_reg;
  assign out_valid = out_valid_reg;
  assign out_data  = head_reg;

endmodule

module easyaxi_rd_slice (
  input  logic                    clk,
  input  logic                    rst_n,
  // upstream (master side)
  input  logic                    axi_slv_arvalid,
  output logic                    axi_slv_arready,
  input  logic [`AXI_ID_W-1:0]    axi_slv_arid,
  input  logic [`AXI_ADDR_W-1:0]  axi_slv_araddr,
  input  logic [`AXI_LEN_W-1:0]   axi_slv_arlen,
  input  logic [`AXI_SIZE_W-1:0]  axi_slv_arsize,
  input  logic [`AXI_BURST_W-1:0] axi_slv_arburst,
  output logic                    axi_slv_rvalid,
  input  logic                    axi_slv_rready,
  output logic [`AXI_DATA_W-1:0]  axi_slv_rdata,
  output logic [`AXI_RESP_W-1:0]  axi_slv_rresp,
  output logic                    axi_slv_rlast,
  // downstream (slave side)
  output logic                    axi_mst_arvalid,
  input  logic                    axi_mst_arready,
  output logic [`AXI_ID_W-1:0]    axi_mst_arid,
  output logic [`AXI_ADDR_W-1:0]  axi_mst_araddr,
  output logic [`AXI_LEN_W-1:0]   axi_mst_arlen,
  output logic [`AXI_SIZE_W-1:0]  axi_mst_arsize,
  output logic [`AXI_BURST_W-1:0] axi_mst_arburst,
  input  logic                    axi_mst_rvalid,
  output logic                    axi_mst_rready,
  input  logic [`AXI_DATA_W-1:0]  axi_mst_rdata,
  input  logic [`AXI_RESP_W-1:0]  axi_mst_rresp,
  input  logic                    axi_mst_rlast
);

  localparam int AR_W = `AXI_ID_W + `AXI_ADDR_W + `AXI_LEN_W + `AXI_SIZE_W + `AXI_BURST_W;
  localparam int R_W  = `AXI_DATA_W + `AXI_RESP_W + 1;

`ifdef EASYAXI_RD_SLICE_AR_EN
  logic [AR_W-1:0] ar_in_data;
  logic [AR_W-1:0] ar_out_data;

  assign ar_in_data = {axi_slv_arid, axi_slv_araddr, axi_slv_arlen, axi_slv_arsize, axi_slv_arburst};

  easyaxi_rd_slice_skid #(.W(AR_W)) u_ar_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (axi_slv_arvalid),
    .in_ready  (axi_slv_arready),
    .in_data   (ar_in_data),
    .out_valid (axi_mst_arvalid),
    .out_ready (axi_mst_arready),
    .out_data  (ar_out_data)
  );

  assign {axi_mst_arid, axi_mst_araddr, axi_mst_arlen, axi_mst_arsize, axi_mst_arburst} = ar_out_data;
`else
  // Zero-latency AR path: no flops, ready flows straight back upstream
  assign axi_mst_arvalid = axi_slv_arvalid;
  assign axi_slv_arready = axi_mst_arready;
  assign axi_mst_arid    = axi_slv_arid;
  assign axi_mst_araddr  = axi_slv_araddr;
  assign axi_mst_arlen   = axi_slv_arlen;
  assign axi_mst_arsize  = axi_slv_arsize;
  assign axi_mst_arburst = axi_slv_arburst;
`endif

  logic [R_W-1:0] r_in_data;
  logic [R_W-1:0] r_out_data;

  assign r_in_data = {axi_mst_rdata, axi_mst_rresp, axi_mst_rlast};

  easyaxi_rd_slice_skid #(.W(R_W)) u_r_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (axi_mst_rvalid),
    .in_ready  (axi_mst_rready),
    .in_data   (r_in_data),
    .out_valid (axi_slv_rvalid),
    .out_ready (axi_slv_rready),
    .out_data  (r_out_data)
  );

  assign {axi_slv_rdata, axi_slv_rresp, axi_slv_rlast} = r_out_data;

endmodule
